// File: rtl/apb_uart_stream_bridge.sv
// Purpose : APB master bridging s_/m_ byte streams to the apb_uart TBR/RBR registers.
// Latency : 4 cycles minimum per byte (IDLE decision, SETUP, ACCESS, GAP); m_valid rises on the read-completion edge.
// Backpr. : s_ready low while the one-entry hold is occupied; RX reads stall on rx_fifo_empty or an unaccepted m_valid.
// Ports   : clk/rst (async, active-high); s_valid/s_ready/s_data TX byte in; m_valid/m_ready/m_data RX byte out;
//           tx_fifo_full/rx_fifo_empty sideband from apb_uart; PSEL..PRDATA APB master; err/err_clr sticky
//           error; busy = transfer in progress.
module apb_uart_stream_bridge #(
    parameter logic [31:0] TBR_ADDR = 32'h0000_0014,
    parameter logic [31:0] RBR_ADDR = 32'h0000_0018,
    parameter int unsigned TIMEOUT  = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic [7:0]  s_data,
    output logic        m_valid,
    input  logic        m_ready,
    output logic [7:0]  m_data,
    input  logic        tx_fifo_full,
    input  logic        rx_fifo_empty,
    output logic        PSEL,
    output logic        PENABLE,
    output logic        PWRITE,
    output logic [31:0] PADDR,
    output logic [31:0] PWDATA,
    input  logic        PREADY,
    input  logic        PSLVERR,
    input  logic [31:0] PRDATA,
    output logic        err,
    input  logic        err_clr,
    output logic        busy
);

    localparam logic [7:0] LP_TMO = 8'(TIMEOUT);

    typedef enum logic [1:0] {ST_IDLE, ST_SETUP, ST_ACCESS, ST_GAP} state_t;

    state_t     r_state;
    state_t     w_state_nxt;
    logic       r_hold_vld;
    logic [7:0] r_hold_dat;
    logic       r_op_wr;
    logic       r_last_rx;      // 1: previous grant went to RX, so TX wins the next tie
    logic [7:0] r_tmo_cnt;
    logic       r_m_valid;
    logic [7:0] r_m_data;
    logic       r_err;

    logic       w_tx_elig;
    logic       w_rx_elig;
    logic       w_grant_wr;
    logic       w_start;
    logic       w_done;
    logic       w_fail;
    logic       w_hold_load;
    logic       w_unused_prdata;

    // Only the low byte of RBR carries data.
    assign w_unused_prdata = ^PRDATA[31:8];

    assign w_hold_load = s_valid && !r_hold_vld;

    always_comb begin
        w_tx_elig   = r_hold_vld && !tx_fifo_full;
        w_rx_elig   = !rx_fifo_empty && !r_m_valid;
        w_grant_wr  = w_tx_elig && (!w_rx_elig || r_last_rx);
        w_start     = (r_state == ST_IDLE) && (w_tx_elig || w_rx_elig);
        // A PREADY on the final allowed cycle still counts as a completion.
        w_done      = (r_state == ST_ACCESS) && (PREADY || (r_tmo_cnt == LP_TMO));
        w_fail      = w_done && (!PREADY || PSLVERR);
        w_state_nxt = r_state;
        PSEL        = 1'b0;
        PENABLE     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_start) w_state_nxt = ST_SETUP;
            end
            ST_SETUP: begin
                PSEL        = 1'b1;
                w_state_nxt = ST_ACCESS;
            end
            ST_ACCESS: begin
                PSEL    = 1'b1;
                PENABLE = 1'b1;
                if (w_done) w_state_nxt = ST_GAP;
            end
            ST_GAP: begin
                w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Address/data derive from the latched op and the hold byte, both frozen for the
    // whole transfer, and are forced to zero outside SETUP/ACCESS.
    assign PWRITE  = PSEL && r_op_wr;
    assign PADDR   = PSEL ? (r_op_wr ? TBR_ADDR : RBR_ADDR) : 32'h0;
    assign PWDATA  = PWRITE ? {24'h0, r_hold_dat} : 32'h0;
    assign s_ready = !r_hold_vld;
    assign m_valid = r_m_valid;
    assign m_data  = r_m_data;
    assign err     = r_err;
    assign busy    = (r_state != ST_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hold_vld <= 1'b0;
            r_hold_dat <= 8'h0;
            r_op_wr    <= 1'b0;
            r_last_rx  <= 1'b1;
            r_tmo_cnt  <= 8'h0;
            r_m_valid  <= 1'b0;
            r_m_data   <= 8'h0;
            r_err      <= 1'b0;
        end else begin
            if (w_start) begin
                r_op_wr   <= w_grant_wr;
                r_last_rx <= !w_grant_wr;
            end

            if (r_state == ST_SETUP)               r_tmo_cnt <= 8'd1;
            else if (r_state == ST_ACCESS && !w_done) r_tmo_cnt <= r_tmo_cnt + 8'd1;
            else                                   r_tmo_cnt <= 8'h0;

            // Errored or timed-out writes drop the byte just like a good write.
            if (w_hold_load) begin
                r_hold_vld <= 1'b1;
                r_hold_dat <= s_data;
            end else if (w_done && r_op_wr) begin
                r_hold_vld <= 1'b0;
            end

            if (w_done && !r_op_wr && !w_fail) begin
                r_m_valid <= 1'b1;
                r_m_data  <= PRDATA[7:0];
            end else if (r_m_valid && m_ready) begin
                r_m_valid <= 1'b0;
            end

            if (w_fail)       r_err <= 1'b1;
            else if (err_clr) r_err <= 1'b0;
        end
    end

endmodule

// File: tb/tb_apb_uart_stream_bridge.sv
// Purpose : scoreboard bench for apb_uart_stream_bridge; expected APB transfers and RX bytes are queued by stimulus.
// Latency : monitor pops on each completed APB transfer and each m_ handshake, sampled on the falling edge.
// Backpr. : the APB slave model and sideband flags are driven directly by the directed scenarios.
module tb_apb_uart_stream_bridge;

    localparam logic [31:0] TBR = 32'h0000_0014;
    localparam logic [31:0] RBR = 32'h0000_0018;

    typedef struct packed {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
    } apb_exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic [7:0]  s_data = 8'h0;
    logic        m_valid;
    logic        m_ready = 1'b0;
    logic [7:0]  m_data;
    logic        tx_fifo_full = 1'b0;
    logic        rx_fifo_empty = 1'b1;
    logic        PSEL, PENABLE, PWRITE;
    logic [31:0] PADDR, PWDATA;
    logic        PREADY = 1'b1;
    logic        PSLVERR = 1'b0;
    logic [31:0] PRDATA = 32'h0;
    logic        err;
    logic        err_clr = 1'b0;
    logic        busy;

    int          n_pass = 0;
    int          n_total = 0;
    int          cyc = 0;
    apb_exp_t    exp_apb[$];
    logic [7:0]  exp_rx[$];
    int          stamps[$];

    apb_uart_stream_bridge #(.TBR_ADDR(TBR), .RBR_ADDR(RBR), .TIMEOUT(16)) dut (
        .clk(clk), .rst(rst),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .tx_fifo_full(tx_fifo_full), .rx_fifo_empty(rx_fifo_empty),
        .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
        .PREADY(PREADY), .PSLVERR(PSLVERR), .PRDATA(PRDATA),
        .err(err), .err_clr(err_clr), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Inputs change 2 ns after the rising edge; outputs are stable there.
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic send(input logic [7:0] b);
        logic rdy;
        logic ok;
        ok      = 1'b0;
        s_valid = 1'b1;
        s_data  = b;
        for (int i = 0; i < 200; i++) begin
            rdy = s_ready;
            step();
            if (rdy) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("send_timeout", 32'(ok), 32'd1);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 100) begin
            step();
            n++;
        end
        if (busy) chk("idle_timeout", 32'(busy), 32'd0);
    endtask

    task automatic wait_psel(input string name);
        int n;
        n = 0;
        while (!PSEL && n < 50) begin
            step();
            n++;
        end
        if (!PSEL) chk(name, 32'(PSEL), 32'd1);
    endtask

    // Scoreboard monitor: one pop per completed APB transfer and per RX handshake.
    always @(negedge clk) begin
        if (!rst) begin
            if (PSEL && PENABLE && PREADY) begin
                stamps.push_back(cyc);
                if (exp_apb.size() == 0) begin
                    chk("apb_unexpected", {31'h0, PWRITE}, 32'hFFFF_FFFF);
                end else begin
                    apb_exp_t e;
                    e = exp_apb.pop_front();
                    chk("apb_pwrite", {31'h0, PWRITE}, {31'h0, e.wr});
                    chk("apb_paddr", PADDR, e.addr);
                    chk("apb_pwdata", PWDATA, e.wdata);
                end
            end
            if (m_valid && m_ready) begin
                if (exp_rx.size() == 0) chk("rx_unexpected", {24'h0, m_data}, 32'hFFFF_FFFF);
                else chk("rx_data", {24'h0, m_data}, {24'h0, exp_rx.pop_front()});
            end
        end
    end

    initial begin
        int n;
        int nr;

        // Reset values.
        step();
        chk("rst_psel", 32'(PSEL), 0);
        chk("rst_penable", 32'(PENABLE), 0);
        chk("rst_pwrite", 32'(PWRITE), 0);
        chk("rst_paddr", PADDR, 0);
        chk("rst_pwdata", PWDATA, 0);
        chk("rst_s_ready", 32'(s_ready), 1);
        chk("rst_m_valid", 32'(m_valid), 0);
        chk("rst_m_data", {24'h0, m_data}, 0);
        chk("rst_err", 32'(err), 0);
        chk("rst_busy", 32'(busy), 0);
        rst = 1'b0;
        step();

        // Single TX.
        exp_apb.push_back('{1'b1, TBR, 32'h0000_00A5});
        send(8'hA5);
        s_valid = 1'b0;
        n = 0;
        for (int i = 0; i < 10; i++) begin
            if (PSEL) n++;
            step();
        end
        chk("tx_psel_cycles", n, 2);
        chk("tx_s_ready_back", 32'(s_ready), 1);

        // Single RX, data held until m_ready.
        PRDATA = 32'hFFFF_FF3C;
        exp_apb.push_back('{1'b0, RBR, 32'h0});
        rx_fifo_empty = 1'b0;
        wait_psel("rx_psel_timeout");
        rx_fifo_empty = 1'b1;
        n = 0;
        while (!m_valid && n < 20) begin
            step();
            n++;
        end
        repeat (3) step();
        chk("rx_m_valid_held", 32'(m_valid), 1);
        chk("rx_m_data_held", {24'h0, m_data}, 32'h3C);
        chk("rx_busy_done", 32'(busy), 0);
        exp_rx.push_back(8'h3C);
        m_ready = 1'b1;
        step();
        m_ready = 1'b0;
        chk("rx_m_valid_clr", 32'(m_valid), 0);

        // Arbitration: both eligible, TX wins first (last grant RX), then alternate.
        tx_fifo_full = 1'b1;
        send(8'h11);
        PRDATA = 32'h0000_0081;
        exp_apb.push_back('{1'b1, TBR, 32'h11});
        exp_apb.push_back('{1'b0, RBR, 32'h0});
        exp_apb.push_back('{1'b1, TBR, 32'h22});
        exp_apb.push_back('{1'b0, RBR, 32'h0});
        exp_apb.push_back('{1'b1, TBR, 32'h33});
        exp_apb.push_back('{1'b0, RBR, 32'h0});
        repeat (3) exp_rx.push_back(8'h81);
        stamps.delete();
        tx_fifo_full  = 1'b0;
        rx_fifo_empty = 1'b0;
        m_ready       = 1'b1;
        fork
            begin
                send(8'h22);
                send(8'h33);
                s_valid = 1'b0;
            end
            begin
                nr = 0;
                for (int i = 0; i < 100; i++) begin
                    if (PSEL && !PENABLE && !PWRITE) nr++;
                    if (nr == 3) begin
                        rx_fifo_empty = 1'b1;
                        break;
                    end
                    step();
                end
                rx_fifo_empty = 1'b1;
            end
        join
        wait_idle();
        step();
        chk("arb_count", stamps.size(), 6);
        for (int i = 1; i < 6; i++) begin
            if (i < stamps.size()) chk("arb_spacing", stamps[i] - stamps[i-1], 4);
        end
        m_ready = 1'b0;

        // Backpressure from tx_fifo_full.
        tx_fifo_full = 1'b1;
        send(8'h5A);
        s_valid = 1'b0;
        n = 0;
        for (int i = 0; i < 8; i++) begin
            if (PSEL) n++;
            step();
        end
        chk("bp_no_apb", n, 0);
        chk("bp_s_ready", 32'(s_ready), 0);
        exp_apb.push_back('{1'b1, TBR, 32'h5A});
        tx_fifo_full = 1'b0;
        n = 0;
        while (!PSEL && n < 10) begin
            step();
            n++;
        end
        chk("bp_release_latency", 32'(n <= 2 && PSEL), 1);
        wait_idle();

        // Timeout on a write: 16 ACCESS cycles, byte dropped, err set.
        PREADY = 1'b0;
        send(8'h77);
        s_valid = 1'b0;
        n = 0;
        for (int i = 0; i < 60; i++) begin
            if (PENABLE) n++;
            if (n > 0 && !PSEL) break;
            step();
        end
        chk("tmo_access_cycles", n, 16);
        chk("tmo_err", 32'(err), 1);
        chk("tmo_s_ready", 32'(s_ready), 1);
        wait_idle();

        // Read with PSLVERR: data discarded, err stays.
        PREADY  = 1'b1;
        PSLVERR = 1'b1;
        PRDATA  = 32'h0000_00EE;
        exp_apb.push_back('{1'b0, RBR, 32'h0});
        rx_fifo_empty = 1'b0;
        wait_psel("slverr_psel_timeout");
        rx_fifo_empty = 1'b1;
        wait_idle();
        step();
        PSLVERR = 1'b0;
        chk("slverr_m_valid", 32'(m_valid), 0);
        chk("slverr_err", 32'(err), 1);
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        chk("err_clr", 32'(err), 0);

        // Asynchronous reset in the middle of ACCESS.
        PREADY = 1'b0;
        send(8'h99);
        s_valid = 1'b0;
        n = 0;
        while (!PENABLE && n < 20) begin
            step();
            n++;
        end
        chk("arst_reached_access", 32'(PENABLE), 1);
        #3 rst = 1'b1;
        #1;
        chk("arst_psel", 32'(PSEL), 0);
        chk("arst_penable", 32'(PENABLE), 0);
        chk("arst_s_ready", 32'(s_ready), 1);
        chk("arst_m_valid", 32'(m_valid), 0);
        chk("arst_busy", 32'(busy), 0);
        step();
        rst    = 1'b0;
        PREADY = 1'b1;
        repeat (4) step();
        chk("end_busy", 32'(busy), 0);
        chk("end_apb_queue", exp_apb.size(), 0);
        chk("end_rx_queue", exp_rx.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
